rgb_frame_fetch: RTL

RGB_FRAME_FETCH -- requirements
Module: rgb_frame_fetch

---
 rtl/rgb_frame_fetch.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/rgb_frame_fetch.sv
// Streams a packed RGB frame (3 SRAM words per 2 pixels) from SRAM into a pixel FIFO.
// Define RGB_FETCH_LOOP_EN to refetch the frame continuously instead of stopping after one pass.
//
// state  | meaning
// IDLE   | waiting for start after reset
// ISSUE0 | read word0 of a group (R0,G0)
// ISSUE1 | read word1 of a group (B0,R1)
// ISSUE2 | read word2 of a group (G1,B1), decide next group
// HOLD   | FIFO credit exhausted, waiting for room
// DRAIN  | all groups issued, waiting for reads and FIFO to empty
// DONE   | frame fully delivered, waiting for start
module rgb_frame_fetch #(
    parameter logic [17:0] RGB_BASE   = 18'd146944,
    parameter logic [15:0] NUM_GROUPS = 16'd38400,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        CLOCK_50_I,
    input  logic        Resetn,
    input  logic        start,
    input  logic [15:0] SRAM_read_data,
    output logic [17:0] address,
    output logic        write_en_n,
    input  logic        pix_ready,
    output logic        pix_valid,
    output logic [7:0]  pix_r,
    output logic [7:0]  pix_g,
    output logic [7:0]  pix_b,
    output logic        pix_first,
    output logic        done
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = CW + 1;

    typedef enum logic [2:0] {
        IDLE, ISSUE0, ISSUE1, ISSUE2, HOLD, DRAIN, DONE
    } state_t;

    state_t      state;
    logic [15:0] grp_cnt;

    logic        s1_v, s2_v, s1_f, s2_f;
    logic [1:0]  s1_w, s2_w;
    logic [7:0]  lat_r, lat_g, lat_r1;
    logic        lat_f;

    logic [24:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] occ, pend;
    logic [SW-1:0] fill;
    logic          credit, push, pop;
    logic [24:0]   push_data;
    logic [24:0]   head;

    assign write_en_n = 1'b1;

    // Pixels already reserved: queued ones plus those of groups still in the read pipe.
    assign fill   = SW'(occ) + SW'(pend);
    assign credit = (fill <= SW'(FIFO_DEPTH - 2));

    assign pix_valid = (occ != '0);
    assign pop       = pix_valid && pix_ready;
    assign head      = fifo_mem[rd_ptr];
    assign pix_first = pix_valid ? head[24]    : 1'b0;
    assign pix_r     = pix_valid ? head[23:16] : 8'd0;
    assign pix_g     = pix_valid ? head[15:8]  : 8'd0;
    assign pix_b     = pix_valid ? head[7:0]   : 8'd0;

    always_comb begin
        push      = 1'b0;
        push_data = '0;
        if (s2_v) begin
            case (s2_w)
                2'd1: begin
                    push      = 1'b1;
                    push_data = {lat_f, lat_r, lat_g, SRAM_read_data[15:8]};
                end
                2'd2: begin
                    push      = 1'b1;
                    push_data = {1'b0, lat_r1, SRAM_read_data};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            state   <= IDLE;
            address <= RGB_BASE;
            grp_cnt <= '0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        address <= RGB_BASE;
                        grp_cnt <= '0;
                        done    <= 1'b0;
                        state   <= credit ? ISSUE0 : HOLD;
                    end
                end
                ISSUE0: begin
                    address <= address + 18'd1;
                    state   <= ISSUE1;
                end
                ISSUE1: begin
                    address <= address + 18'd1;
                    state   <= ISSUE2;
                end
                ISSUE2: begin
                    if (grp_cnt == NUM_GROUPS - 16'd1) begin
`ifdef RGB_FETCH_LOOP_EN
                        address <= RGB_BASE;
                        grp_cnt <= '0;
                        state   <= credit ? ISSUE0 : HOLD;
`else
                        address <= address + 18'd1;
                        state   <= DRAIN;
`endif
                    end else begin
                        address <= address + 18'd1;
                        grp_cnt <= grp_cnt + 16'd1;
                        state   <= credit ? ISSUE0 : HOLD;
                    end
                end
                HOLD: begin
                    if (credit) state <= ISSUE0;
                end
                DRAIN: begin
                    if (!s1_v && !s2_v && (occ == '0)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-stage tag pipe matches the SRAM's address-to-data latency.
    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            s1_v   <= 1'b0;
            s1_w   <= 2'd0;
            s1_f   <= 1'b0;
            s2_v   <= 1'b0;
            s2_w   <= 2'd0;
            s2_f   <= 1'b0;
            lat_r  <= 8'd0;
            lat_g  <= 8'd0;
            lat_r1 <= 8'd0;
            lat_f  <= 1'b0;
        end else begin
            s1_v <= (state == ISSUE0) || (state == ISSUE1) || (state == ISSUE2);
            s1_w <= (state == ISSUE0) ? 2'd0 : ((state == ISSUE1) ? 2'd1 : 2'd2);
            s1_f <= (grp_cnt == 16'd0);
            s2_v <= s1_v;
            s2_w <= s1_w;
            s2_f <= s1_f;
            if (s2_v && (s2_w == 2'd0)) begin
                lat_r <= SRAM_read_data[15:8];
                lat_g <= SRAM_read_data[7:0];
                lat_f <= s2_f;
            end
            if (s2_v && (s2_w == 2'd1)) lat_r1 <= SRAM_read_data[7:0];
        end
    end

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            pend   <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: ;
            endcase
            case ({state == ISSUE0, push})
                2'b10:   pend <= pend + CW'(2);
                2'b11:   pend <= pend + CW'(1);
                2'b01:   pend <= pend - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50_I) begin
        if (push) fifo_mem[wr_ptr] <= push_data;
    end

endmodule
